// File: rtl/register_file_stream_reader_pkg.sv
// Shared definitions for the register file readers: the walker FSM encoding
// and the default widths of the AXI-stream beat fields (tdata = word, tuser = address).
package register_file_stream_reader_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/register_file_stream_reader_if.sv
// AXI-stream beat bundle emitted by the register file readers.
// tuser carries the register address the word was read from.
interface register_file_stream_reader_if
    import register_file_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

    logic [DATA_WIDTH-1:0] tdata;
    logic [ADDR_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/register_file_stream_reader.sv
// Walks a contiguous register file window through one combinational read port
// and emits each word as an AXI-stream beat (address on tuser, tlast on the final word).
module register_file_stream_reader
    import register_file_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    register_file_stream_reader_if.master m
);

    localparam logic [ADDR_WIDTH:0] REMAINING_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic [ADDR_WIDTH-1:0] tuser_reg;
    logic                  tlast_reg;
    logic                  tvalid_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic take_start;
    logic zero_start;
    logic load;
    logic drain_ack;

    // The read port always looks at the walk pointer; the file answers in the same cycle.
    assign rf_addr  = ptr;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign m.tdata  = tdata_reg;
    assign m.tuser  = tuser_reg;
    assign m.tlast  = tlast_reg;
    assign m.tvalid = tvalid_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        take_start = 1'b0;
        zero_start = 1'b0;
        load       = 1'b0;
        drain_ack  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        take_start = 1'b1;
                        state_next = ST_READ;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // The output register refills whenever it is empty or being consumed.
                load = !tvalid_reg || m.tready;
                if (load && (remaining == REMAINING_ONE)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tvalid_reg && m.tready) begin
                    drain_ack  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Window pointers, output beat register and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr        <= '0;
            remaining  <= '0;
            tdata_reg  <= '0;
            tuser_reg  <= '0;
            tlast_reg  <= 1'b0;
            tvalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= zero_start || drain_ack;
            if (take_start) begin
                ptr       <= base_addr;
                remaining <= count;
                busy_reg  <= 1'b1;
            end
            if (load) begin
                tdata_reg  <= rf_data;
                tuser_reg  <= ptr;
                tvalid_reg <= 1'b1;
                tlast_reg  <= (remaining == REMAINING_ONE);
                ptr        <= ptr + 1'b1;
                remaining  <= remaining - 1'b1;
            end
            if (drain_ack) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
                busy_reg   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_stream_reader.sv
// Directed bench for register_file_stream_reader: a register file model with
// same-cycle write forwarding feeds the read port; a negedge monitor logs beats.
module tb_register_file_stream_reader;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    logic [DW-1:0] rf [0:255];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    register_file_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_if ();

    register_file_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .m         (m_if.master)
    );

    always #5 clk = ~clk;

    // Register file read port with write forwarding.
    assign rf_data = (wr_en && (wr_addr == rf_addr)) ? wr_data : rf[rf_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int fails  = 0;
    int s_cyc  = 0;

    // Monitor state (written only by the monitor).
    logic [DW-1:0] q_data [$];
    logic [AW-1:0] q_user [$];
    logic          q_last [$];
    int            q_cyc  [$];
    int            done_cnt    = 0;
    int            done_cyc    = 0;
    int            busy_cycles = 0;
    int            stall_err   = 0;
    int            stall_cycles = 0;
    logic          stall_prev  = 1'b0;
    logic [DW-1:0] sv_data;
    logic [AW-1:0] sv_user;
    logic          sv_last;

    always @(negedge clk) begin
        if (stall_prev) begin
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== sv_data ||
                m_if.tuser !== sv_user || m_if.tlast !== sv_last)
                stall_err++;
        end
        stall_prev = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
        if (stall_prev) stall_cycles++;
        sv_data = m_if.tdata;
        sv_user = m_if.tuser;
        sv_last = m_if.tlast;
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            q_data.push_back(m_if.tdata);
            q_user.push_back(m_if.tuser);
            q_last.push_back(m_if.tlast);
            q_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
        @(posedge clk); #1;
        base_addr = b;
        count     = c;
        start     = 1'b1;
        s_cyc     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
        tests++; if (m_if.tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast got %b want 0", m_if.tlast); end
        tests++; if (rf_addr !== 8'h00) begin fails++; $display("FAIL reset_rf_addr got %h want 00", rf_addr); end
        tests++; if (m_if.tdata !== 32'h0) begin fails++; $display("FAIL reset_tdata got %h want 0", m_if.tdata); end
        tests++; if (m_if.tuser !== 8'h00) begin fails++; $display("FAIL reset_tuser got %h want 00", m_if.tuser); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int n0, d0;
        for (int i = 0; i < 4; i++) rf[8+i] = 32'hA0 + i;
        m_if.tready = 1'b1;
        n0 = q_data.size();
        d0 = done_cnt;
        do_start(8'h08, 9'd4);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (q_data.size() != n0 + 4) begin
            fails++; $display("FAIL basic_beats got %0d want 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (q_data[n0+i] !== 32'hA0 + i) begin fails++; $display("FAIL basic_tdata[%0d] got %h want %h", i, q_data[n0+i], 32'hA0 + i); end
                tests++; if (q_user[n0+i] !== 8'(8 + i)) begin fails++; $display("FAIL basic_tuser[%0d] got %h want %h", i, q_user[n0+i], 8 + i); end
                tests++; if (q_last[n0+i] !== (i == 3)) begin fails++; $display("FAIL basic_tlast[%0d] got %b want %b", i, q_last[n0+i], i == 3); end
                tests++; if (q_cyc[n0+i] != s_cyc + 2 + i) begin fails++; $display("FAIL basic_timing[%0d] got %0d want %0d", i, q_cyc[n0+i], s_cyc + 2 + i); end
            end
        end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
        tests++; if (done_cyc != s_cyc + 6) begin fails++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, s_cyc + 6); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int n0, d0, e0, st0;
        for (int i = 0; i < 4; i++) rf[8+i] = 32'hA0 + i;
        m_if.tready = 1'b1;
        n0 = q_data.size();
        d0 = done_cnt;
        e0 = stall_err;
        st0 = stall_cycles;
        do_start(8'h08, 9'd4);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            m_if.tready = ~m_if.tready;
        end
        m_if.tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (q_data.size() != n0 + 4) begin
            fails++; $display("FAIL bp_beats got %0d want 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (q_data[n0+i] !== 32'hA0 + i) begin fails++; $display("FAIL bp_tdata[%0d] got %h want %h", i, q_data[n0+i], 32'hA0 + i); end
                tests++; if (q_user[n0+i] !== 8'(8 + i)) begin fails++; $display("FAIL bp_tuser[%0d] got %h want %h", i, q_user[n0+i], 8 + i); end
                tests++; if (q_last[n0+i] !== (i == 3)) begin fails++; $display("FAIL bp_tlast[%0d] got %b want %b", i, q_last[n0+i], i == 3); end
            end
        end
        tests++; if (stall_cycles - st0 == 0) begin fails++; $display("FAIL bp_stalls got 0 want >0"); end
        tests++; if (stall_err - e0 != 0) begin fails++; $display("FAIL bp_stability got %0d unstable stalls want 0", stall_err - e0); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL bp_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        int n0;
        logic [AW-1:0] exp_user [4];
        exp_user[0] = 8'hFE; exp_user[1] = 8'hFF; exp_user[2] = 8'h00; exp_user[3] = 8'h01;
        for (int i = 0; i < 4; i++) rf[exp_user[i]] = 32'hC0 + i;
        m_if.tready = 1'b1;
        n0 = q_data.size();
        do_start(8'hFE, 9'd4);
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (q_data.size() != n0 + 4) begin
            fails++; $display("FAIL wrap_beats got %0d want 4", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (q_user[n0+i] !== exp_user[i]) begin fails++; $display("FAIL wrap_tuser[%0d] got %h want %h", i, q_user[n0+i], exp_user[i]); end
                tests++; if (q_data[n0+i] !== 32'hC0 + i) begin fails++; $display("FAIL wrap_tdata[%0d] got %h want %h", i, q_data[n0+i], 32'hC0 + i); end
                tests++; if (q_last[n0+i] !== (i == 3)) begin fails++; $display("FAIL wrap_tlast[%0d] got %b want %b", i, q_last[n0+i], i == 3); end
            end
        end
    endtask

    task automatic test_count_zero();
        int n0, d0, b0;
        n0 = q_data.size();
        d0 = done_cnt;
        b0 = busy_cycles;
        do_start(8'h10, 9'd0);
        repeat (5) @(posedge clk);
        #1;
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); end
        tests++; if (done_cyc != s_cyc + 1) begin fails++; $display("FAIL zero_done_cycle got %0d want %0d", done_cyc, s_cyc + 1); end
        tests++; if (q_data.size() != n0) begin fails++; $display("FAIL zero_beats got %0d want 0", q_data.size() - n0); end
        tests++; if (busy_cycles != b0) begin fails++; $display("FAIL zero_busy got %0d busy cycles want 0", busy_cycles - b0); end
    endtask

    task automatic test_reset_midstream();
        int n0, d0, n1, d1, k;
        for (int i = 0; i < 6; i++) rf[8'h20 + i] = 32'hD0 + i;
        rf[0] = 32'hE7;
        m_if.tready = 1'b1;
        n0 = q_data.size();
        d0 = done_cnt;
        do_start(8'h20, 9'd6);
        k = 0;
        while (q_data.size() < n0 + 2 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        tests++; if (q_data.size() < n0 + 2) begin fails++; $display("FAIL rstmid_wait got %0d beats want 2", q_data.size() - n0); end
        reset = 1'b0;
        @(negedge clk); #1;
        tests++; if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid got %b want 0", m_if.tvalid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests++; if (done_cnt - d0 != 0) begin fails++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); end
        tests++; if (q_data.size() != n0 + 2) begin fails++; $display("FAIL rstmid_beats got %0d want 2", q_data.size() - n0); end
        n1 = q_data.size();
        d1 = done_cnt;
        do_start(8'h00, 9'd1);
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (q_data.size() != n1 + 1) begin
            fails++; $display("FAIL rstmid_restart_beats got %0d want 1", q_data.size() - n1);
        end else begin
            tests++; if (q_data[n1] !== 32'hE7) begin fails++; $display("FAIL rstmid_restart_tdata got %h want e7", q_data[n1]); end
            tests++; if (q_user[n1] !== 8'h00) begin fails++; $display("FAIL rstmid_restart_tuser got %h want 00", q_user[n1]); end
            tests++; if (q_last[n1] !== 1'b1) begin fails++; $display("FAIL rstmid_restart_tlast got %b want 1", q_last[n1]); end
        end
        tests++; if (done_cnt - d1 != 1) begin fails++; $display("FAIL rstmid_restart_done got %0d want 1", done_cnt - d1); end
    endtask

    task automatic test_coherency();
        int n0, d0;
        logic [DW-1:0] exp_data [3];
        rf[8] = 32'hB0; rf[9] = 32'hB1; rf[10] = 32'hB2;
        exp_data[0] = 32'hB0; exp_data[1] = 32'h55; exp_data[2] = 32'hB2;
        m_if.tready = 1'b1;
        n0 = q_data.size();
        d0 = done_cnt;
        do_start(8'h08, 9'd3);
        // Cycle s+2: word 9 is loaded; write it and pulse start while busy.
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 8'h09; wr_data = 32'h55;
        base_addr = 8'h40; count = 9'd5; start = 1'b1;
        @(posedge clk); #1;
        rf[9] = 32'h55;
        wr_en = 1'b0;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        tests++;
        if (q_data.size() != n0 + 3) begin
            fails++; $display("FAIL coh_beats got %0d want 3", q_data.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (q_data[n0+i] !== exp_data[i]) begin fails++; $display("FAIL coh_tdata[%0d] got %h want %h", i, q_data[n0+i], exp_data[i]); end
                tests++; if (q_user[n0+i] !== 8'(8 + i)) begin fails++; $display("FAIL coh_tuser[%0d] got %h want %h", i, q_user[n0+i], 8 + i); end
            end
        end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL coh_done_count got %0d want 1", done_cnt - d0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL coh_busy_end got %b want 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_count_zero();
        test_reset_midstream();
        test_coherency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
